// File: rtl/p2s_pkg.sv
// Shared types and constants for the blk_par2ser parallel-to-serial stage.
package p2s_pkg;

  localparam int unsigned LANES    = 4;
  localparam int unsigned IDX_W    = 2;
  localparam int unsigned SAMPLE_W = 5;
  localparam int unsigned CNT_W    = 2;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef sample_t [LANES-1:0]        block_t;

  // True when the lane index points at the final sample (y4) of a block.
  function automatic logic is_last_lane(input logic [IDX_W-1:0] lane);
    return lane == IDX_W'(LANES - 1);
  endfunction

endpackage

// File: rtl/p2s_block_fifo.sv
// Block storage for blk_par2ser: holds whole y1..y4 blocks.
// Depth is 2 (ping-pong) when BLK_P2S_DBUF_EN is defined, otherwise 1.
module p2s_block_fifo
  import p2s_pkg::*;
#(
  parameter int unsigned W = SAMPLE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [LANES-1:0][W-1:0] wr_block,
  input  logic                  pop_blk,
  output logic [LANES-1:0][W-1:0] rd_block,
  output logic                  in_ready,
  output logic                  not_empty
);

  logic [CNT_W-1:0] count;
  logic             push_en;
  logic             pop_en;
  logic             wr_ptr;
  logic             rd_ptr;

  assign push_en = push && in_ready;
  assign pop_en  = pop_blk && not_empty;

`ifdef BLK_P2S_DBUF_EN
  localparam int unsigned DEPTH = 2;

  // Ping-pong pointers toggle on each accepted push / released block.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push_en) wr_ptr <= ~wr_ptr;
      if (pop_en)  rd_ptr <= ~rd_ptr;
    end
  end
`else
  localparam int unsigned DEPTH = 1;

  // Single block register: both pointers permanently address entry 0.
  assign wr_ptr = 1'b0;
  assign rd_ptr = 1'b0;
`endif

  logic [LANES-1:0][W-1:0] mem [DEPTH];

  // Flags come straight from the count register, never from out_ready.
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign not_empty = (count != '0);
  assign rd_block  = mem[rd_ptr];

  // Occupancy: a push and a release in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({push_en, pop_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sample storage; stale contents are masked by count after reset.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= wr_block;
  end

endmodule

// File: rtl/blk_par2ser.sv
// Parallel-to-serial output stage: accepts y1..y4 blocks and emits them
// one sample per cycle on a valid/ready stream.
// Optional macro BLK_P2S_DBUF_EN selects a 2-deep block buffer for full rate.
module blk_par2ser
  import p2s_pkg::*;
#(
  parameter int unsigned W = SAMPLE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] y1,
  input  logic signed [W-1:0] y2,
  input  logic signed [W-1:0] y3,
  input  logic signed [W-1:0] y4,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_data,
  output logic [IDX_W-1:0]    out_idx,
  output logic                out_last
);

  logic [LANES-1:0][W-1:0] wr_block;
  logic [LANES-1:0][W-1:0] rd_block;
  logic [IDX_W-1:0]        idx;
  logic                    not_empty;
  logic                    pop;
  logic                    blk_done;

  // Lane 0 carries y1 (oldest) so idx walks the block in arrival order.
  assign wr_block = {y4, y3, y2, y1};
  assign pop      = not_empty && out_ready;
  assign blk_done = pop && is_last_lane(idx);

  p2s_block_fifo #(.W(W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid),
    .wr_block  (wr_block),
    .pop_blk   (blk_done),
    .rd_block  (rd_block),
    .in_ready  (in_ready),
    .not_empty (not_empty)
  );

  // Lane counter: advances on every accepted sample, wraps after y4.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (pop) begin
      idx <= idx + IDX_W'(1);
    end
  end

  // Output mux; everything is zeroed while no block is buffered.
  assign out_valid = not_empty;
  assign out_data  = not_empty ? rd_block[idx] : '0;
  assign out_idx   = not_empty ? idx : '0;
  assign out_last  = not_empty && is_last_lane(idx);

endmodule

// File: tb/tb_blk_par2ser.sv
// Self-checking bench for blk_par2ser (either BLK_P2S_DBUF_EN build).
module tb_blk_par2ser;

  localparam int W = 5;
`ifdef BLK_P2S_DBUF_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  typedef struct {
    logic signed [W-1:0] data;
    logic [1:0]          idx;
    logic                last;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] y1, y2, y3, y4;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_data;
  logic [1:0]          out_idx;
  logic                out_last;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic accepted;
  int   pops;
  int   bubbles;
  logic track;

  always #5 clk = ~clk;

  blk_par2ser #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y1        (y1),
    .y2        (y2),
    .y3        (y3),
    .y4        (y4),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  // One clock: observe at negedge (scoreboard push/pop), then drive at posedge+1.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (rst) begin
      q.delete();
    end else begin
      if (in_valid && in_ready) begin
        q.push_back('{y1, 2'd0, 1'b0});
        q.push_back('{y2, 2'd1, 1'b0});
        q.push_back('{y3, 2'd2, 1'b0});
        q.push_back('{y4, 2'd3, 1'b1});
        accepted = 1'b1;
      end
      if (out_valid) begin
        if (out_ready) begin
          n_checks++;
          if (q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got data=%0d idx=%0d with nothing expected", out_data, out_idx);
          end else begin
            e = q.pop_front();
            if (out_data !== e.data || out_idx !== e.idx || out_last !== e.last) begin
              n_fail++;
              $display("FAIL sb_sample: got data=%0d idx=%0d last=%0b, want data=%0d idx=%0d last=%0b",
                       out_data, out_idx, out_last, e.data, e.idx, e.last);
            end
          end
          pops++;
        end
      end else begin
        n_checks++;
        if (out_data !== '0 || out_idx !== 2'd0 || out_last !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_zero: got data=%0d idx=%0d last=%0b, want 0 0 0", out_data, out_idx, out_last);
        end
        if (track) bubbles++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                       input logic signed [W-1:0] c, input logic signed [W-1:0] d);
    accepted = 1'b0;
    in_valid = 1'b1;
    y1 = a; y2 = b; y3 = c; y4 = d;
    for (int i = 0; i < 30; i++) begin
      step();
      if (accepted) break;
    end
    in_valid = 1'b0;
    n_checks++;
    if (!accepted) begin
      n_fail++;
      $display("FAIL offer_timeout: block %0d,%0d,%0d,%0d not accepted, want accepted", a, b, c, d);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (q.size() == 0 && !out_valid) break;
      step();
    end
    n_checks++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: got %0d samples pending, out_valid=%0b, want 0 and 0", q.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    y1 = '0; y2 = '0; y3 = '0; y4 = '0;
    step(); step();
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0 || out_idx !== 2'd0 || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%0b ready=%0b data=%0d idx=%0d last=%0b, want 0 1 0 0 0",
               out_valid, in_ready, out_data, out_idx, out_last);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    offer(-5'sd11, 5'sd12, 5'sd5, 5'sd8);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 5'b10101 || out_idx !== 2'd0 || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_latency: got valid=%0b data=%b idx=%0d last=%0b, want 1 10101 0 0",
               out_valid, out_data, out_idx, out_last);
    end
    drain();
  endtask

  task automatic test_stall();
    out_ready = 1'b1;
    offer(5'sd8, -5'sd16, 5'sd0, 5'sd5);
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 5'b10000 || out_idx !== 2'd1 || out_last !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold: cycle %0d got valid=%0b data=%b idx=%0d, want 1 10000 1",
                 i, out_valid, out_data, out_idx);
      end
      step();
    end
    out_ready = 1'b1;
    drain();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    pops = 0; bubbles = 0;
    offer(5'sd1, -5'sd2, 5'sd3, -5'sd4);
    track = 1'b1;
    pops = 0;
    offer(5'sd15, -5'sd15, 5'sd7, -5'sd1);
    for (int i = 0; i < 40; i++) begin
      if (pops >= 7) break;
      step();
    end
    track = 1'b0;
    n_checks++;
    if (bubbles != DEPTH % 2) begin
      n_fail++;
      $display("FAIL b2b_bubbles: got %0d idle cycles between blocks, want %0d", bubbles, DEPTH % 2);
    end
    drain();
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    for (int b = 0; b < DEPTH; b++) offer(5'(b + 2), 5'(b + 3), 5'(-b - 4), 5'(b + 9));
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ready: got in_ready=%0b after %0d blocks, want 0", in_ready, DEPTH);
    end
    accepted = 1'b0;
    in_valid = 1'b1;
    y1 = 5'sd13; y2 = 5'sd13; y3 = 5'sd13; y4 = 5'sd13;
    for (int i = 0; i < 3; i++) step();
    in_valid = 1'b0;
    n_checks++;
    if (accepted !== 1'b0 || in_ready !== 1'b0 || q.size() != 4 * DEPTH) begin
      n_fail++;
      $display("FAIL full_ignore: got accepted=%0b in_ready=%0b pending=%0d, want 0 0 %0d",
               accepted, in_ready, q.size(), 4 * DEPTH);
    end
    out_ready = 1'b1;
    drain();
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b1;
    offer(5'sd7, 5'sd6, -5'sd5, 5'sd4);
    step(); step();
    n_checks++;
    if (out_idx !== 2'd2 || out_data !== -5'sd5) begin
      n_fail++;
      $display("FAIL mid_pre: got idx=%0d data=%0d, want 2 -5", out_idx, out_data);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1 || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got valid=%0b data=%0d ready=%0b last=%0b, want 0 0 1 0",
               out_valid, out_data, in_ready, out_last);
    end
    offer(5'sd1, 5'sd2, 5'sd3, 5'sd4);
    n_checks++;
    if (out_data !== 5'sd1 || out_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_restart: got data=%0d idx=%0d, want 1 0", out_data, out_idx);
    end
    drain();
  endtask

  initial begin
    track = 1'b0; accepted = 1'b0; pops = 0; bubbles = 0;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_full();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
